// File: rtl/split_sequencer_pkg.sv
// ============================================================================
// split_sequencer_pkg : shared widths, state encoding and chunk-order indices
// Build option: SPLIT_MSB_FIRST_EN selects most-significant-chunk-first order.
// Revision: 1.0
// ============================================================================
`default_nettype none

package split_sequencer_pkg;

  localparam int IN_W_DEF   = 32;
  localparam int OUT_W_DEF  = 16;
  localparam int CHUNKS_DEF = 2;
  localparam int CNT_W_DEF  = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

`ifdef SPLIT_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  // Index of the first / final chunk presented for a product of 'chunks' slices.
  function automatic int first_idx(input int chunks);
    return MSB_FIRST ? chunks - 1 : 0;
  endfunction

  function automatic int last_idx(input int chunks);
    return MSB_FIRST ? 0 : chunks - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/split_chunk_mux.sv
// ============================================================================
// split_chunk_mux : combinational selector of one OUT_W slice of a hold word
// Revision: 1.0
// ============================================================================
`default_nettype none

module split_chunk_mux
  import split_sequencer_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int CHUNKS = CHUNKS_DEF,
  parameter int CNT_W  = $clog2(CHUNKS)
) (
  input  logic [IN_W-1:0]  hold,
  input  logic [CNT_W-1:0] sel,
  output logic [OUT_W-1:0] data
);

  logic [OUT_W-1:0] slices [CHUNKS];

  for (genvar i = 0; i < CHUNKS; i++) begin : g_slice
    assign slices[i] = hold[i*OUT_W +: OUT_W];
  end

  // Explicit compare loop keeps out-of-range indices (non power-of-two CHUNKS) at zero.
  always_comb begin
    data = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (sel == CNT_W'(i)) data = slices[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/split_sequencer.sv
// ============================================================================
// split_sequencer : serialises one wide product into CHUNKS narrow stream words
// Build option: SPLIT_MSB_FIRST_EN (via split_sequencer_pkg) reverses chunk order.
// Revision: 1.0
// ============================================================================
`default_nettype none

module split_sequencer
  import split_sequencer_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int CHUNKS = CHUNKS_DEF,
  parameter int CNT_W  = $clog2(CHUNKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] chunk_sel,
  output logic             busy
);

  localparam logic [CNT_W-1:0] FIRST_SEL = CNT_W'(first_idx(CHUNKS));
  localparam logic [CNT_W-1:0] LAST_SEL  = CNT_W'(last_idx(CHUNKS));

  state_e           state_q, state_d;
  logic [IN_W-1:0]  hold_q,  hold_d;
  logic [CNT_W-1:0] sel_q,   sel_d;
  logic [CNT_W-1:0] sel_step;
  logic             accept;

  assign busy      = (state_q == ST_SEND);
  assign out_valid = busy;
  assign out_last  = busy && (sel_q == LAST_SEL);
  assign chunk_sel = sel_q;
  assign sel_step  = MSB_FIRST ? (sel_q - CNT_W'(1)) : (sel_q + CNT_W'(1));

  // Ready depends only on state and the downstream handshake, never on in_valid.
  assign in_ready = rst_n && !flush && ((state_q == ST_IDLE) || (out_last && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    if (flush) begin
      state_d = ST_IDLE;
      hold_d  = '0;
      sel_d   = '0;
    end else if (accept) begin
      // Covers both the idle capture and the zero-bubble reload on the last chunk.
      state_d = ST_SEND;
      hold_d  = in_data;
      sel_d   = FIRST_SEL;
    end else if (busy && out_ready) begin
      if (out_last) state_d = ST_IDLE;
      else          sel_d   = sel_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
    end
  end

  split_chunk_mux #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .CHUNKS (CHUNKS),
    .CNT_W  (CNT_W)
  ) u_chunk_mux (
    .hold (hold_q),
    .sel  (sel_q),
    .data (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_split_sequencer.sv
// Testbench for split_sequencer: directed scenarios plus a randomized run against
// a chunk-queue reference model. Honours SPLIT_MSB_FIRST_EN for chunk order.
`default_nettype none

module tb_split_sequencer;

  localparam int IN_W   = 32;
  localparam int OUT_W  = 16;
  localparam int CHUNKS = 2;
  localparam int CNT_W  = 1;
  localparam int VW     = OUT_W + CNT_W + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, out_last, busy;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] chunk_sel;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [CNT_W-1:0] s;
    logic             l;
  } chunk_t;

  always #5 clk = ~clk;

  split_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .CHUNKS(CHUNKS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .chunk_sel(chunk_sel), .busy(busy)
  );

  // k-th emitted chunk of a product: its index and its slice of the product.
  function automatic int exp_sel(input int k);
`ifdef SPLIT_MSB_FIRST_EN
    return CHUNKS - 1 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic [OUT_W-1:0] exp_data(input logic [IN_W-1:0] p, input int k);
    return OUT_W'(p >> (exp_sel(k) * OUT_W));
  endfunction

  // {out_valid, out_data, chunk_sel, out_last, in_ready} expected while chunk k is shown.
  function automatic logic [VW-1:0] exp_vec(input logic [IN_W-1:0] p, input int k, input logic rdy);
    return {1'b1, exp_data(p, k), CNT_W'(exp_sel(k)), (k == CHUNKS - 1), rdy};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_last} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_asserted: got rdy/vld/busy/last=%b want 0000", {in_ready, out_valid, busy, out_last});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, chunk_sel} !== {3'b100, CNT_W'(0)}) begin
      failures++;
      $display("FAIL reset_release: got rdy/vld/busy=%b sel=%0d want 100 sel=0", {in_ready, out_valid, busy}, chunk_sel);
    end
  endtask

  task automatic test_single();
    logic [IN_W-1:0] p = 32'hDEAD_BEEF;
    logic [VW-1:0] e;
    @(negedge clk);
    in_valid = 1'b1; in_data = p; out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL single_idle: got rdy/vld=%b want 10", {in_ready, out_valid});
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < CHUNKS; k++) begin
      #1;
      e = exp_vec(p, k, k == CHUNKS - 1);
      checks++;
      if ({out_valid, out_data, chunk_sel, out_last, in_ready} !== e) begin
        failures++;
        $display("FAIL single_chunk%0d: got %h want %h", k, {out_valid, out_data, chunk_sel, out_last, in_ready}, e);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL single_done: got vld/busy/rdy=%b want 001", {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [IN_W-1:0] prods [2];
    logic [VW-1:0] e;
    prods[0] = 32'h1111_2222;
    prods[1] = 32'h3333_4444;
    @(negedge clk);
    in_valid = 1'b1; in_data = prods[0]; out_ready = 1'b1;
    @(negedge clk);
    in_data = prods[1];
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < CHUNKS; k++) begin
        #1;
        e = exp_vec(prods[p], k, k == CHUNKS - 1);
        checks++;
        if ({out_valid, out_data, chunk_sel, out_last, in_ready} !== e) begin
          failures++;
          $display("FAIL b2b_p%0d_chunk%0d: got %h want %h", p, k, {out_valid, out_data, chunk_sel, out_last, in_ready}, e);
        end
        @(negedge clk);
        if (p == 0 && k == CHUNKS - 1) in_valid = 1'b0;
      end
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [IN_W-1:0] p = 32'hA5A5_0F0F;
    logic [VW-1:0] e;
    @(negedge clk);
    in_valid = 1'b1; in_data = p; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      e = exp_vec(p, 0, 1'b0);
      checks++;
      if ({out_valid, out_data, chunk_sel, out_last, in_ready} !== e) begin
        failures++;
        $display("FAIL stall_cycle%0d: got %h want %h", s, {out_valid, out_data, chunk_sel, out_last, in_ready}, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < CHUNKS; k++) begin
      #1;
      e = exp_vec(p, k, k == CHUNKS - 1);
      checks++;
      if ({out_valid, out_data, chunk_sel, out_last, in_ready} !== e) begin
        failures++;
        $display("FAIL stall_release_chunk%0d: got %h want %h", k, {out_valid, out_data, chunk_sel, out_last, in_ready}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    logic [IN_W-1:0] p = 32'hCAFE_F00D;
    logic [VW-1:0] e;
    @(negedge clk);
    in_valid = 1'b1; in_data = p; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    e = exp_vec(p, 0, 1'b0);
    checks++;
    if ({out_valid, out_data, chunk_sel, out_last, in_ready} !== e) begin
      failures++;
      $display("FAIL flush_first_chunk: got %h want %h", {out_valid, out_data, chunk_sel, out_last, in_ready}, e);
    end
    @(negedge clk);
    // Flush with a competing new product: the accept must be overridden.
    flush = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, chunk_sel} !== {3'b001, CNT_W'(0)}) begin
      failures++;
      $display("FAIL flush_idle: got vld/busy/rdy=%b sel=%0d want 001 sel=0", {out_valid, busy, in_ready}, chunk_sel);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_residue: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [IN_W-1:0] q = 32'h0BAD_F00D;
    logic [VW-1:0] e;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h5555_AAAA; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset: got vld/busy/rdy=%b want 000", {out_valid, busy, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_data = q; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL async_release: got vld/rdy=%b want 01", {out_valid, in_ready});
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < CHUNKS; k++) begin
      #1;
      e = exp_vec(q, k, k == CHUNKS - 1);
      checks++;
      if ({out_valid, out_data, chunk_sel, out_last, in_ready} !== e) begin
        failures++;
        $display("FAIL post_reset_chunk%0d: got %h want %h", k, {out_valid, out_data, chunk_sel, out_last, in_ready}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    chunk_t q[$];
    chunk_t c;
    logic exp_valid, exp_rdy;
    q.delete();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      exp_valid = (q.size() != 0);
      exp_rdy   = !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
      checks++;
      if ({out_valid, busy} !== {exp_valid, exp_valid}) begin
        failures++;
        $display("FAIL rand_valid cyc%0d: got vld/busy=%b want %b", n, {out_valid, busy}, {exp_valid, exp_valid});
      end
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rand_in_ready cyc%0d: got %b want %b", n, in_ready, exp_rdy);
      end
      if (exp_valid) begin
        checks++;
        if ({out_data, chunk_sel, out_last} !== q[0]) begin
          failures++;
          $display("FAIL rand_chunk cyc%0d: got %h want %h", n, {out_data, chunk_sel, out_last}, q[0]);
        end
      end
      if (flush) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          for (int k = 0; k < CHUNKS; k++) begin
            c.d = exp_data(in_data, k);
            c.s = CNT_W'(exp_sel(k));
            c.l = (k == CHUNKS - 1);
            q.push_back(c);
          end
        end
      end
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
